// File: rtl/mean_pkg.sv
// Shared definitions for the frame-mean sequencer: FSM state encoding and
// the constants used to normalise the adder-tree sum into an 8-bit mean.
package mean_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [8:0] ROUND_BIAS = 9'd128;
    localparam int         AVG_LSB    = 8;

endpackage

// File: rtl/mean_round.sv
// Normalises the adder-tree sum to an 8-bit mean: optional round-half-up bias
// (MEAN_SEQ_ROUND_EN) followed by selecting bits [15:8]; bits [31:16] are ignored.
module mean_round
    import mean_pkg::*;
(
    input  logic [31:0] sum_in,
    output logic [7:0]  avg
);

    logic [16:0] biased;
    logic [24:0] unused_bits;

    // Bias the low half (17 bits wide so the worst case 65280+128 cannot wrap) and select the mean byte
    always_comb begin
`ifdef MEAN_SEQ_ROUND_EN
        biased = {1'b0, sum_in[15:0]} + {8'd0, ROUND_BIAS};
`else
        biased = {1'b0, sum_in[15:0]};
`endif
        avg = biased[AVG_LSB +: 8];
    end

    assign unused_bits = {sum_in[31:16], biased[16], biased[7:0]};

endmodule

// File: rtl/mean_sequencer.sv
// Frame sequencer: clears the adder tree, streams NUM_ROWS rows, waits for the
// tree latency, then latches the normalised mean. Rounding via MEAN_SEQ_ROUND_EN.
module mean_sequencer
    import mean_pkg::*;
#(
    parameter int NUM_ROWS = 32,
    parameter int TREE_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        tree_clr,
    output logic [4:0]  row_sel,
    output logic        row_valid,
    input  logic [31:0] sum_in,
    output logic [7:0]  avg,
    output logic        done
);

    localparam logic [4:0] LAST_ROW   = 5'(NUM_ROWS - 1);
    localparam logic [3:0] DRAIN_LAST = 4'(TREE_LAT);

    state_t      state_r, state_s;
    logic [4:0]  row_sel_r, row_sel_s;
    logic [3:0]  drain_cnt_r, drain_cnt_s;
    logic        busy_r, tree_clr_r, row_valid_r, done_r;
    logic [7:0]  avg_r, avg_s;

    mean_round u_round (
        .sum_in (sum_in),
        .avg    (avg_s)
    );

    // Next-state and counter update; outputs are registered from the next state
    always_comb begin
        state_s     = state_r;
        row_sel_s   = row_sel_r;
        drain_cnt_s = drain_cnt_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = CLEAR;
                end else begin
                    state_s = IDLE;
                end
            end
            CLEAR: begin
                state_s   = STREAM;
                row_sel_s = 5'd0;
            end
            STREAM: begin
                if (row_sel_r == LAST_ROW) begin
                    state_s     = DRAIN;
                    drain_cnt_s = 4'd0;
                end else begin
                    row_sel_s = row_sel_r + 5'd1;
                end
            end
            DRAIN: begin
                if (drain_cnt_r == DRAIN_LAST) begin
                    state_s = DONE;
                end else begin
                    drain_cnt_s = drain_cnt_r + 4'd1;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            row_sel_r   <= 5'd0;
            drain_cnt_r <= 4'd0;
            busy_r      <= 1'b0;
            tree_clr_r  <= 1'b0;
            row_valid_r <= 1'b0;
            done_r      <= 1'b0;
            avg_r       <= 8'd0;
        end else begin
            state_r     <= state_s;
            row_sel_r   <= row_sel_s;
            drain_cnt_r <= drain_cnt_s;
            busy_r      <= (state_s != IDLE);
            tree_clr_r  <= (state_s == CLEAR);
            row_valid_r <= (state_s == STREAM);
            done_r      <= (state_s == DONE);
            if (state_s == DONE) begin
                avg_r <= avg_s;
            end
        end
    end

    assign busy      = busy_r;
    assign tree_clr  = tree_clr_r;
    assign row_sel   = row_sel_r;
    assign row_valid = row_valid_r;
    assign done      = done_r;
    assign avg       = avg_r;

endmodule

// File: tb/tb_mean_sequencer.sv
// Self-checking bench for mean_sequencer: phase-based reference model checked
// every cycle, table-driven normalisation vectors, and multi-cycle corner sequences.
module tb_mean_sequencer;

    localparam int N       = 32;
    localparam int L       = 4;
    localparam int DONE_PH = N + L + 2;
`ifdef MEAN_SEQ_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, start2;
    logic [31:0] sum_in;
    logic        busy, tree_clr, row_valid, done;
    logic [4:0]  row_sel;
    logic [7:0]  avg;
    logic        busy2, tree_clr2, row_valid2, done2;
    logic [4:0]  row_sel2;
    logic [7:0]  avg2;

    always #5 clk = ~clk;

    mean_sequencer #(.NUM_ROWS(N), .TREE_LAT(L)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .tree_clr(tree_clr),
        .row_sel(row_sel), .row_valid(row_valid), .sum_in(sum_in), .avg(avg), .done(done)
    );

    mean_sequencer #(.NUM_ROWS(1), .TREE_LAT(1)) dut_small (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .tree_clr(tree_clr2),
        .row_sel(row_sel2), .row_valid(row_valid2), .sum_in(sum_in), .avg(avg2), .done(done2)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_avg(input logic [31:0] s);
        int v;
        v = int'(s[15:0]) + (RND ? 128 : 0);
        return 8'((v / 256) % 256);
    endfunction

    // Reference model: phase = edges since the accepting edge, -1 when idle
    int         m_phase = -1;
    logic [4:0] m_row   = 5'd0;
    logic [7:0] m_avg   = 8'd0;
    int         edge_no = 0;

    task automatic step();
        @(posedge clk);
        edge_no++;
        if (!rst) begin
            m_phase = -1;
            m_row   = 5'd0;
            m_avg   = 8'd0;
        end else begin
            if (m_phase < 0) begin
                if (start) m_phase = 0;
            end else if (m_phase == DONE_PH) begin
                m_phase = -1;
            end else begin
                m_phase++;
            end
            if (m_phase >= 1 && m_phase <= N) m_row = 5'(m_phase - 1);
            if (m_phase == DONE_PH) m_avg = ref_avg(sum_in);
        end
        @(negedge clk);
        check("busy",      busy,      m_phase >= 0);
        check("tree_clr",  tree_clr,  m_phase == 0);
        check("row_valid", row_valid, m_phase >= 1 && m_phase <= N);
        check("row_sel",   row_sel,   m_row);
        check("done",      done,      m_phase == DONE_PH);
        check("avg",       avg,       m_avg);
    endtask

    task automatic run_frame();
        int s0, clr_cnt, rv_cnt, lat;
        bit seen;
        start = 1'b1;
        step();
        s0 = edge_no;
        start = 1'b0;
        clr_cnt = int'(tree_clr);
        rv_cnt = 0;
        seen = 1'b0;
        lat = -1;
        for (int i = 0; i < 60 && !seen; i++) begin
            step();
            clr_cnt += int'(tree_clr);
            rv_cnt  += int'(row_valid);
            if (done) begin
                seen = 1'b1;
                lat = edge_no - s0;
            end
        end
        check("done_latency", lat, DONE_PH);
        check("tree_clr_count", clr_cnt, 1);
        check("row_valid_count", rv_cnt, N);
        step();
    endtask

    typedef struct {
        logic [31:0] sum;
        logic [7:0]  rnd;
        logic [7:0]  trn;
    } vec_t;

    vec_t tab[7];

    initial begin
        int dn[$];
        int cnt, k_done, rv_cnt;

        tab[0] = '{32'h0000_7F80, 8'h80, 8'h7F};
        tab[1] = '{32'h0000_FF00, 8'hFF, 8'hFF};
        tab[2] = '{32'h0000_0000, 8'h00, 8'h00};
        tab[3] = '{32'h0000_00FF, 8'h01, 8'h00};
        tab[4] = '{32'h1234_5680, 8'h57, 8'h56};
        tab[5] = '{32'hABCD_017F, 8'h01, 8'h01};
        tab[6] = '{32'hFFFF_0180, 8'h02, 8'h01};

        rst = 1'b0; start = 1'b1; start2 = 1'b0; sum_in = 32'd0;
        step();
        step();
        rst = 1'b1; start = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            sum_in = tab[i].sum;
            run_frame();
            check("avg_table", avg, RND ? tab[i].rnd : tab[i].trn);
        end

        // start held high: back-to-back frames with one IDLE cycle between
        start = 1'b1;
        for (int i = 0; i < 200 && dn.size() < 3; i++) begin
            sum_in = 32'($urandom_range(0, 65280));
            step();
            if (done) dn.push_back(edge_no);
        end
        start = 1'b0;
        check("held_done_count", dn.size(), 3);
        if (dn.size() == 3) begin
            check("held_spacing_a", dn[1] - dn[0], DONE_PH + 2);
            check("held_spacing_b", dn[2] - dn[1], DONE_PH + 2);
        end
        for (int i = 0; i < 3; i++) step();

        // reset mid-frame at row_sel=10
        sum_in = 32'h0000_3C00;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 50 && !(row_valid && row_sel == 5'd10); i++) step();
        check("reset_at_row", row_sel, 5'd10);
        rst = 1'b0;
        step();
        check("reset_busy", busy, 1'b0);
        check("reset_avg", avg, 8'd0);
        rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            cnt += int'(done);
        end
        check("reset_no_done", cnt, 0);
        sum_in = 32'h0000_4000;
        run_frame();
        check("after_reset_avg", avg, ref_avg(32'h0000_4000));

        // randomized traffic including occasional resets
        for (int i = 0; i < 600; i++) begin
            start  = ($urandom_range(0, 3) == 0);
            sum_in = {16'($urandom), 16'($urandom_range(0, 65280))};
            rst    = ($urandom_range(0, 99) != 0);
            step();
        end
        rst = 1'b1; start = 1'b0;
        for (int i = 0; i < 50; i++) step();

        // NUM_ROWS=1, TREE_LAT=1 instance
        sum_in = 32'h0000_1280;
        start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0;
        check("small_tree_clr", tree_clr2, 1'b1);
        rv_cnt = 0;
        k_done = -1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (row_valid2) begin
                rv_cnt++;
                check("small_row_sel", row_sel2, 5'd0);
            end
            if (done2 && k_done < 0) k_done = k;
        end
        check("small_done_edge", k_done, 4);
        check("small_rv_count", rv_cnt, 1);
        check("small_avg", avg2, ref_avg(32'h0000_1280));
        check("small_idle", busy2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mean_sequencer.md
MEAN_SEQUENCER -- requirements
Module: mean_sequencer

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 32, rows streamed per frame (legal 1..32).
REQ-002 SHALL have parameter TREE_LAT, default 4, cycles from the last row_valid until sum_in is final (legal 1..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-005 SHALL have port start, input, 1, frame request; sampled only in IDLE.
REQ-006 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-007 SHALL have port tree_clr, output, 1, one-cycle clear pulse to the adder-tree accumulator.
REQ-008 SHALL have port row_sel, output, 5, mux row selector.
REQ-009 SHALL have port row_valid, output, 1, adder-tree in_valid.
REQ-010 SHALL have port sum_in, input, 32, adder-tree sum.
REQ-011 SHALL have port avg, output, 8, normalized frame mean.
REQ-012 SHALL have port done, output, 1, one-cycle pulse when avg updates.

Function
REQ-013 SHALL implement the states IDLE, CLEAR, STREAM, DRAIN and DONE; all outputs SHALL be registered.
REQ-014 SHALL move IDLE -> CLEAR on the edge sampling start=1; tree_clr=1 only while in CLEAR.
REQ-015 SHALL move CLEAR -> STREAM unconditionally, with row_sel=0 and row_valid=1.
REQ-016 SHALL, in STREAM, increment row_sel by 1 per cycle with row_valid=1; after the cycle with row_sel=NUM_ROWS-1 it SHALL move to DRAIN with row_valid=0 and row_sel held at its last value.
REQ-017 SHALL, in DRAIN, count TREE_LAT cycles, then sample sum_in into avg on the edge entering DONE.
REQ-018 SHALL, in DONE, assert done=1 for exactly one cycle, then return to IDLE.
REQ-019 SHALL compute avg = sum_in[15:8] after the Configuration adjustment; sum_in[31:16] SHALL be ignored.
REQ-020 SHALL raise done exactly NUM_ROWS+TREE_LAT+2 edges after the edge that sampled start.
REQ-021 SHALL ignore start while busy=1, including in DONE; a held start SHALL begin a new frame on the first IDLE cycle.
REQ-022 SHALL hold avg between frames; it changes only on done.
REQ-023 SHALL produce exactly one tree_clr per accepted frame, and no row_valid outside STREAM.

Reset
REQ-024 SHALL, while rst=0 at an edge, force state=IDLE, busy=0, tree_clr=0, row_sel=0, row_valid=0, avg=0 and done=0.
REQ-025 SHALL, when reset is asserted mid-frame, abandon the frame without a done pulse and leave avg at 0.
REQ-026 SHALL ignore start on the first edge after rst rises only if it is sampled with rst=0.

Configuration
REQ-027 SHALL, when MEAN_SEQ_ROUND_EN is defined, add 128 to sum_in before taking bits [15:8] (round-half-up).
REQ-028 SHALL, when MEAN_SEQ_ROUND_EN is not defined, truncate with no addend.
REQ-029 SHALL have no overflow in either mode, because the sum is at most 65280 plus 128.

Structure
REQ-030 SHALL take the state encoding (3-bit), ROUND_BIAS=128 and AVG_LSB=8 from a shared package, mean_pkg.
REQ-031 SHALL place rounding plus bit-select in one combinational sub-module, mean_round (32-bit in, 8-bit out, macro-dependent).
REQ-032 SHALL keep the drain counter 4 bits wide and the row counter 5 bits wide, with no wrap beyond NUM_ROWS-1.

Verification
REQ-033 Bench SHALL check: one start pulse, defaults -> tree_clr one cycle, row_sel 0..31 on 32 consecutive row_valid cycles, done at edge 38.
REQ-034 Bench SHALL check: sum_in=0x7F80 with rounding -> avg=0x80; without rounding -> avg=0x7F.
REQ-035 Bench SHALL check: sum_in=65280 (all samples 255), rounding on -> avg=0xFF, no wrap.
REQ-036 Bench SHALL check: start held high continuously -> back-to-back frames, each done 38 edges after its CLEAR-entry edge, one IDLE cycle between frames.
REQ-037 Bench SHALL check: rst=0 at row_sel=10 -> next cycle all outputs 0, no done, and a fresh start then runs a full frame.
REQ-038 Bench SHALL check: NUM_ROWS=1, TREE_LAT=1 -> a single row_valid with row_sel=0, done 4 edges after start.
